// File: rtl/drum_mixer.sv
// Drum voice mixer: strobes the voice players, sums attenuated unmuted voices, saturates, writes to codec.
// Optional MIX_CLIP_EN adds a sticky clip flag (clip) with clear input (clip_clr).
module drum_mixer #(
  parameter int NUM_VOICES = 4,
  parameter int SAMPLE_W   = 16,
  parameter int ROM_LAT    = 2
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic [NUM_VOICES*SAMPLE_W-1:0]   voice_in,
  input  logic [NUM_VOICES-1:0]            mute,
  input  logic [2*NUM_VOICES-1:0]          atten,
  output logic                             sample_en,
  input  logic                             write_ready,
  output logic                             write,
  output logic signed [SAMPLE_W-1:0]       audio_out,
  output logic                             busy
`ifdef MIX_CLIP_EN
  ,
  input  logic                             clip_clr,
  output logic                             clip
`endif
);

  localparam int ACC_W  = SAMPLE_W + 3;
  localparam int IDX_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int WAIT_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
  localparam logic [IDX_W-1:0]  LAST_VOICE = IDX_W'(NUM_VOICES - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(ROM_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_STROBE, S_WAIT, S_ACCUM, S_SAT, S_WRITE
  } state_t;

  state_t                    state;
  logic signed [ACC_W-1:0]   acc;
  logic [IDX_W-1:0]          vidx;
  logic [WAIT_W-1:0]         wait_cnt;

  logic signed [SAMPLE_W-1:0] cur_voice;
  logic                       cur_mute;
  logic [1:0]                 cur_sh;
  logic signed [ACC_W-1:0]    cur_ext;
  logic signed [ACC_W-1:0]    cur_term;

  // Overflow when the bits above the output sign bit disagree with it.
  function automatic logic sat_hit(input logic signed [ACC_W-1:0] a);
    return !((&a[ACC_W-1:SAMPLE_W-1]) || !(|a[ACC_W-1:SAMPLE_W-1]));
  endfunction

  function automatic logic signed [SAMPLE_W-1:0] saturate(input logic signed [ACC_W-1:0] a);
    if (!sat_hit(a))
      return a[SAMPLE_W-1:0];
    else if (a[ACC_W-1])
      return {1'b1, {(SAMPLE_W-1){1'b0}}};
    else
      return {1'b0, {(SAMPLE_W-1){1'b1}}};
  endfunction

  always_comb begin
    cur_voice = '0;
    cur_mute  = 1'b0;
    cur_sh    = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (vidx == IDX_W'(i)) begin
        cur_voice = voice_in[i*SAMPLE_W +: SAMPLE_W];
        cur_mute  = mute[i];
        cur_sh    = atten[2*i +: 2];
      end
    end
  end

  assign cur_ext  = {{(ACC_W-SAMPLE_W){cur_voice[SAMPLE_W-1]}}, cur_voice};
  assign cur_term = cur_ext >>> cur_sh;

  assign write = (state == S_WRITE) && write_ready;
  assign busy  = (state != S_IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      sample_en <= 1'b0;
      audio_out <= '0;
      acc       <= '0;
      vidx      <= '0;
      wait_cnt  <= '0;
    end else begin
      sample_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (write_ready) begin
            state     <= S_STROBE;
            sample_en <= 1'b1;
          end
        end
        S_STROBE: begin
          acc      <= '0;
          vidx     <= '0;
          wait_cnt <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt == WAIT_LAST) state <= S_ACCUM;
          else                       wait_cnt <= wait_cnt + 1'b1;
        end
        S_ACCUM: begin
          if (!cur_mute) acc <= acc + cur_term;
          if (vidx == LAST_VOICE) state <= S_SAT;
          else                    vidx  <= vidx + 1'b1;
        end
        S_SAT: begin
          audio_out <= saturate(acc);
          state     <= S_WRITE;
        end
        S_WRITE: begin
          // Hold the sample (and stop strobing voices) until the codec accepts it.
          if (write_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef MIX_CLIP_EN
  // Set has priority over clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      clip <= 1'b0;
    else if (state == S_SAT && sat_hit(acc))
      clip <= 1'b1;
    else if (clip_clr)
      clip <= 1'b0;
  end
`endif

endmodule

// File: doc/drum_mixer.md
Name: drum_mixer

Overview:
- Downstream consumer of the per-voice sample players (snare, kick, hi-hat, ...).
- Paces the voices with a one-cycle sample-advance strobe, waits for their ROM data, then sums the attenuated, unmuted voices one per cycle.
- Saturates the sum to 16 bits and hands it to the audio codec write port with a ready/write handshake.
- One mixed sample per codec write.

Parameters:
- NUM_VOICES, 4, number of voice inputs; legal range 1..8.
- SAMPLE_W, 16, width of each signed voice sample and of audio_out.
- ROM_LAT, 2, cycles from the sample_en strobe until voice data is valid: 1 cycle counter increment + 1 cycle registered ROM read.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- resetn  input  1  asynchronous, active-low reset.
- voice_in  input  NUM_VOICES*SAMPLE_W  packed signed samples; voice i occupies bits [i*SAMPLE_W +: SAMPLE_W].
- mute  input  NUM_VOICES  1 = voice i excluded from the sum.
- atten  input  2*NUM_VOICES  per-voice arithmetic right-shift amount 0..3; voice i occupies bits [2i +: 2].
- sample_en  output  1  one-cycle strobe to the voices' en inputs; advances every voice by one sample.
- write_ready  input  1  codec FIFO has space.
- write  output  1  codec write strobe; audio_out is valid whenever write=1.
- audio_out  output  SAMPLE_W  saturated mixed sample, signed.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (async assert): state=IDLE; sample_en=0, write=0, audio_out=0, busy=0, accumulator=0.
  - Reset asserted mid-frame aborts the frame; no write is issued for it.
- Accumulator width ACC_W = SAMPLE_W+3, signed; cannot overflow for up to 8 voices.
- FSM states: IDLE, STROBE, WAIT, ACCUM, SAT, WRITE.
- IDLE: if write_ready=1, go to STROBE; otherwise stay.
- STROBE (1 cycle): sample_en=1; clear accumulator and voice index; go to WAIT.
- WAIT: ROM_LAT cycles, then go to ACCUM.
- ACCUM: NUM_VOICES cycles; voice index i counts 0..NUM_VOICES-1.
  - If mute[i]=0: acc += sign_extend(voice_i >>> atten_i).
  - mute and atten are sampled in the same cycle as the voice they apply to.
- SAT (1 cycle): register audio_out.
  - acc > 2^(SAMPLE_W-1)-1 → 0x7FFF.
  - acc < -2^(SAMPLE_W-1) → 0x8000.
  - Otherwise acc truncated to SAMPLE_W bits.
- WRITE: write = write_ready, combinational within this state.
  - On a cycle with write_ready=1, assert write for exactly that cycle, then go to IDLE.
  - While write_ready=0, hold WRITE with write=0; audio_out stays stable.
- Latency: sample_en in cycle T → earliest write in cycle T+ROM_LAT+NUM_VOICES+2. With defaults this is T+8.
- audio_out changes only in SAT and holds until the next SAT.
- No sample_en is issued while a sample is waiting in WRITE: voices never advance past an unwritten sample.
- Back-to-back: with write_ready held at 1, frames repeat every ROM_LAT+NUM_VOICES+4 cycles (10 with defaults).
- Arithmetic shift rounds toward negative infinity (-3 >>> 1 = -2).

Optional Feature:
- Macro MIX_CLIP_EN.
- Defined: adds input clip_clr (1 bit) and output clip (1 bit, reset 0).
  - clip is set in any SAT cycle where saturation occurred and stays set until clip_clr=1 is sampled.
  - If set and clear occur in the same cycle, set wins.
- Undefined: neither port exists; saturation behaviour is unchanged.

Test Plan:
- Single voice: voice0=1000, others muted, atten=0, write_ready=1 → sample_en at T, write at T+8, audio_out=1000.
- Saturation: all four voices=20000, unmuted, atten=0 → audio_out=0x7FFF. All four=-20000 → audio_out=0x8000. With MIX_CLIP_EN, clip=1 after either case.
- Attenuation: voice0=0x4000 atten=2, voice1=-3 atten=1, others muted → audio_out=0x1000-2=0x0FFE.
- Backpressure: drop write_ready at T+7 for 5 cycles → write=0 throughout, audio_out stable, no second sample_en. Raise ready → single write pulse, then IDLE, then sample_en.
- Reset mid-ACCUM: deassert resetn at T+4 → immediately write=0, audio_out=0, busy=0. After release, the next frame completes normally with the correct sum.
- Continuous stream: write_ready=1 for 100 cycles → sample_en every 10 cycles and write every 10 cycles, each write 8 cycles after its strobe.
